// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage registers (IF/ID, ID/EX, EX/MEM,
// MEM/WB): skid-buffer state encoding, stall counter width and a saturating
// increment helper.
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Occupancy of a 2-entry skid stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int unsigned STALL_CNT_W = 32;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        logic [STALL_CNT_W-1:0] r;
        r = v;
        if (v != {STALL_CNT_W{1'b1}}) begin
            r = v + STALL_CNT_W'(1);
        end
        return r;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_sat_cnt.sv
// ---------------------------------------------------------------------------
// pipe_sat_cnt
// Saturating event counter used for the stage's downstream-stall statistic.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, clears the count
//   inc_i  - count one event this cycle
//   cnt_o  - current count, saturates at all-ones
// ---------------------------------------------------------------------------
module pipe_sat_cnt
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc_i,
    output logic [STALL_CNT_W-1:0] cnt_o
);

    logic [STALL_CNT_W-1:0] cnt_q;
    logic [STALL_CNT_W-1:0] cnt_d;

    // Next count.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : pipe_sat_cnt

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
// Two-entry skid-buffered pipeline stage register with flush. The main
// register drives out_data; the skid register catches the entry accepted in
// the cycle downstream stalls, so in_ready can be a pure flop output.
// Optional feature macro: PIPE_STALL_CNT_EN (adds the stall counter; when
// undefined stall_cnt is tied to zero and no counter flops exist).
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   flush               - squash every held entry at the next edge
//   in_valid/in_ready   - upstream handshake, in_data payload
//   out_valid/out_ready - downstream handshake, out_data payload (oldest)
//   stall_cnt           - cycles with out_valid=1 and out_ready=0
// ---------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_q;
    logic             in_ready_q;

    logic accept;
    logic consume;

    // Handshakes use only the registered flags, so no ready/valid comb path.
    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid_q & out_ready;

    // Next-state and datapath selection.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Whatever was accepted this cycle is dropped along with the rest.
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (consume) begin
                        main_d  = BUBBLE_VAL;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (consume) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // State, payload and handshake-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE_VAL;
            skid_q      <= BUBBLE_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            // Flags are decoded from the next state so they are flops too.
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != TWO);
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;

`ifdef PIPE_STALL_CNT_EN
    logic stall_inc;

    // A stall is a live output that downstream does not take.
    assign stall_inc = out_valid_q & ~out_ready;

    pipe_sat_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
// Directed bench for pipe_skid_stage with a queue-based reference: accepted
// payloads are pushed, consumed ones popped, and every cycle the DUT's
// out_valid/in_ready/out_data/stall_cnt are compared with the queue state.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int unsigned W         = 32;
    localparam logic [W-1:0] TB_BUBBLE = 32'hB0B0_B0B0;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           out_data;
    logic [STALL_CNT_W-1:0] stall_cnt;

    int unsigned compared;
    int unsigned mismatched;

    logic [W-1:0]           exp_q[$];
    logic [STALL_CNT_W-1:0] exp_stall;
    bit                     last_acc;

    pipe_skid_stage #(
        .WIDTH      (W),
        .BUBBLE_VAL (TB_BUBBLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare outputs with the reference, advance the reference, clock once.
    task automatic step(input bit chk);
        bit acc;
        bit con;
        if (chk) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
            check("out_data",  out_data, (exp_q.size() > 0) ? exp_q[0] : TB_BUBBLE);
            check("stall_cnt", stall_cnt, exp_stall);
        end
        acc = in_valid && (exp_q.size() < 2);
        con = (exp_q.size() > 0) && out_ready;
`ifdef PIPE_STALL_CNT_EN
        if ((exp_q.size() > 0) && !out_ready && (exp_stall != {STALL_CNT_W{1'b1}})) begin
            exp_stall = exp_stall + STALL_CNT_W'(1);
        end
`endif
        if (rst) begin
            exp_q.delete();
            exp_stall = '0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            if (con) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(in_data);
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        exp_stall  = '0;
        last_acc   = 1'b0;
        rst        = 1'b1;
        out_ready  = 1'b0;
        idle_inputs();

        // Reset, then reset-state checks.
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  out_data, TB_BUBBLE);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        step(1'b1);

        // Streaming: one transfer per cycle, one-cycle latency.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11; step(1'b1);
        check("stream_lat1", out_data, 32'h11);
        in_data   = 32'h22; step(1'b1);
        check("stream_lat2", out_data, 32'h22);
        in_data   = 32'h33; step(1'b1);
        check("stream_lat3", out_data, 32'h33);
        check("stream_rdy",  32'(in_ready), 32'd1);
        idle_inputs();
        step(1'b1);
        step(1'b1);

        // Backpressure: fill to TWO, hold 0xA2, then release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA0; step(1'b1);
        in_data   = 32'hA1; step(1'b1);
        check("bp_full_rdy", 32'(in_ready), 32'd0);
        in_data   = 32'hA2; step(1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            if (last_acc) break;
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) step(1'b1);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Stall count: one held entry, five stalled cycles.
        rst = 1'b1; step(1'b0); rst = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 32'hC0; step(1'b1);
        idle_inputs();
        for (int i = 0; i < 5; i++) step(1'b1);
`ifdef PIPE_STALL_CNT_EN
        check("stall_5", stall_cnt, 32'd5);
`else
        check("stall_off", stall_cnt, 32'd0);
`endif
        out_ready = 1'b1; step(1'b1); step(1'b1);

        // Flush in TWO with a competing input: nothing survives.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5; step(1'b1);
        in_data   = 32'h6; step(1'b1);
        flush     = 1'b1;
        in_data   = 32'h7; step(1'b1);
        idle_inputs();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_data",  out_data, TB_BUBBLE);
        out_ready = 1'b1;
        step(1'b1);
        step(1'b1);

        // Flush in ONE while an entry is accepted: the new entry is dropped.
        in_valid = 1'b1; in_data = 32'h8; step(1'b1);
        out_ready = 1'b0;
        flush = 1'b1; in_data = 32'h9; step(1'b1);
        idle_inputs();
        check("flush1_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step(1'b1);

`ifdef PIPE_STALL_CNT_EN
        // Saturation: preload near the top and stall past it.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hD0; step(1'b1);
        idle_inputs();
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.cnt_q;
        exp_stall = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(1'b1);
        check("stall_sat", stall_cnt, 32'hFFFF_FFFF);
        out_ready = 1'b1; step(1'b1); step(1'b1);
`endif

        // Reset mid-operation with flush and a valid input.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hDEAD; step(1'b1);
        check("pre_rst_data", out_data, 32'hDEAD);
        rst = 1'b1; flush = 1'b1; in_data = 32'hBEEF; step(1'b1);
        rst = 1'b0;
        idle_inputs();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_rdy",   32'(in_ready),  32'd1);
        check("midrst_stall", stall_cnt, 32'd0);
        step(1'b1);
        step(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_pipe_skid_stage
